// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the add/sub result path: special-value constants,
// the class flag struct and the classifier used by the collector and the formal checkers.
package fpu_pkg;

  localparam logic [31:0] POS_INF  = 32'h7F80_0000;
  localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;
  localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
  localparam logic [31:0] CAN_NAN  = 32'h7FC0_0000;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic denorm;
  } fp_flags_t;

  // Takes the magnitude bits only: the sign never changes the class.
  function automatic fp_flags_t classify_fp32(input logic [30:0] mag);
    fp_flags_t f;
    logic      exp_max;
    logic      exp_min;
    logic      man_nz;
    exp_max  = (mag[30:23] == 8'hFF);
    exp_min  = (mag[30:23] == 8'h00);
    man_nz   = (mag[22:0] != 23'd0);
    f.nan    = exp_max & man_nz;
    f.inf    = exp_max & ~man_nz;
    f.zero   = exp_min & ~man_nz;
    f.denorm = exp_min & man_nz;
    return f;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// First-word fall-through synchronous FIFO; the read port shows zero while empty
// so the head outputs are clean after reset.
module fpu_sync_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FULL_CNT);
  assign count_o   = count_q;
  assign do_pop    = pop_i & ~empty_o;
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    if (push_i && !do_pop)      count_d = count_q + CW'(1);
    else if (!push_i && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the read port is masked while empty.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/fpu_result_collector.sv
// Collects results from the fixed-latency FP32 add/sub pipeline: tracks accepted ops,
// classifies each captured R, keeps sticky flags and buffers results behind a credit scheme.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int RSLT_DLY   = 5,
  parameter  int TAG_BITS   = 4,
  parameter  int FIFO_DEPTH = 8,
  localparam int IFW        = $clog2(RSLT_DLY + 1),
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [TAG_BITS-1:0] issue_tag,
  input  logic [WIDTH-1:0]    R,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [WIDTH-1:0]    res_data,
  output logic [TAG_BITS-1:0] res_tag,
  output logic [3:0]          res_flags,
  output logic [3:0]          sticky_flags,
  input  logic                clr_sticky,
  output logic [IFW-1:0]      in_flight,
  output logic [CW-1:0]       fifo_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and issue_ready depends only on registered counts.

  localparam int DW = WIDTH + TAG_BITS + 4;

  logic [RSLT_DLY-1:0]               vld_q, vld_d;
  logic [RSLT_DLY-1:0][TAG_BITS-1:0] tag_q, tag_d;
  logic [IFW-1:0]                    in_flight_q, in_flight_d;
  logic [3:0]                        sticky_q, sticky_d;
  logic                              accept;
  logic                              tail_push;
  fp_flags_t                         push_flags;
  logic [DW-1:0]                     fifo_wdata;
  logic [DW-1:0]                     fifo_rdata;
  logic                              fifo_full;
  logic                              fifo_empty;

  assign issue_ready = (int'(fifo_count) + int'(in_flight_q)) < FIFO_DEPTH;
  assign accept      = issue_valid & issue_ready;
  assign tail_push   = vld_q[RSLT_DLY-1];
  assign push_flags  = classify_fp32(R[30:0]);
  assign fifo_wdata  = {R, tag_q[RSLT_DLY-1], push_flags};

  always_comb begin
    vld_d       = '0;
    tag_d       = '0;
    in_flight_d = in_flight_q;
    sticky_d    = clr_sticky ? 4'b0000 : sticky_q;
    vld_d[0]    = accept;
    tag_d[0]    = issue_tag;
    for (int i = 1; i < RSLT_DLY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    if (accept && !tail_push)      in_flight_d = in_flight_q + IFW'(1);
    else if (!accept && tail_push) in_flight_d = in_flight_q - IFW'(1);
    if (tail_push) sticky_d = sticky_d | push_flags;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      vld_q       <= '0;
      tag_q       <= '0;
      in_flight_q <= '0;
      sticky_q    <= '0;
    end else begin
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      in_flight_q <= in_flight_d;
      sticky_q    <= sticky_d;
    end
  end

  fpu_sync_fifo #(
    .DATA_W (DW),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .arst_n      (arst_n),
    .push_i      (tail_push),
    .push_data_i (fifo_wdata),
    .pop_i       (res_ready),
    .rd_data_o   (fifo_rdata),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign res_valid    = ~fifo_empty;
  assign res_data     = fifo_rdata[DW-1 -: WIDTH];
  assign res_tag      = fifo_rdata[4 +: TAG_BITS];
  assign res_flags    = fifo_rdata[3:0];
  assign sticky_flags = sticky_q;
  assign in_flight    = in_flight_q;

  // Credit guarantees room for every op in the pipe.
  a_no_overflow: assert property (@(posedge clk) disable iff (!arst_n) !(tail_push && fifo_full));
  a_in_flight_max: assert property (@(posedge clk) disable iff (!arst_n) int'(in_flight_q) <= RSLT_DLY);

endmodule
